// File: rtl/sort_floats_seq_pkg.sv
// Shared types and helpers for the sequential float sorter.
// Element width, FSM state encoding, and compare-count helper.
package sort_floats_seq_pkg;

    localparam int FLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_cmp(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/sort_floats_seq_fle.sv
// Purpose: IEEE-754 a <= b compare; err flags a NaN operand (res forced 0 then).
// Latency: purely combinational.
// Backpressure: none; operands are sampled by the caller every cycle.
module f_less_or_equal
    import sort_floats_seq_pkg::*;
(
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic            res,
    output logic            err
);

    localparam int EW = (FLEN == 32) ? 8 : 11;
    localparam int MW = FLEN - 1 - EW;

    logic            a_sgn, b_sgn;
    logic [FLEN-2:0] a_mag, b_mag;
    logic            a_nan, b_nan;
    logic            both_zero;

    assign a_sgn = a[FLEN-1];
    assign b_sgn = b[FLEN-1];
    assign a_mag = a[FLEN-2:0];
    assign b_mag = b[FLEN-2:0];
    assign a_nan = (&a[FLEN-2 -: EW]) && (|a[MW-1:0]);
    assign b_nan = (&b[FLEN-2 -: EW]) && (|b[MW-1:0]);
    // +0 and -0 compare equal regardless of sign bit
    assign both_zero = ~(|a_mag) && ~(|b_mag);

    always_comb begin
        err = a_nan || b_nan;
        res = 1'b0;
        if (!err) begin
            if (both_zero)
                res = 1'b1;
            else if (a_sgn && !b_sgn)
                res = 1'b1;
            else if (!a_sgn && !b_sgn)
                res = (a_mag <= b_mag);
            else if (a_sgn && b_sgn)
                res = (a_mag >= b_mag);
        end
    end

endmodule

// File: rtl/sort_floats_seq.sv
// Purpose: bubble-sorts N floats with one shared comparator, ascending and stable.
// Latency: result valid N*(N-1)/2 cycles after accept (earlier if a compare errs).
// Backpressure: accepts only in IDLE; result held stable in DONE until down_ready.
module sort_floats_seq
    import sort_floats_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [0:N-1][FLEN-1:0]   up_data,
    output logic                     down_valid,
    input  logic                     down_ready,
    output logic [0:N-1][FLEN-1:0]   down_data,
    output logic                     down_err,
    output logic                     busy
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 2);
    localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

    state_t                   state_q, state_d;
    logic [0:N-1][FLEN-1:0]   elem_q;
    logic [IW-1:0]            idx_q, pass_q, idx_nxt;
    logic                     err_q;
    logic [FLEN-1:0]          cmp_a, cmp_b;
    logic                     cmp_res, cmp_err;
    logic                     accept, step, row_end;

    assign idx_nxt = idx_q + IW'(1);
    assign cmp_a   = elem_q[idx_q];
    assign cmp_b   = elem_q[idx_nxt];
    // each pass bubbles one element into place, so the row shrinks by one
    assign row_end = (idx_q == (LAST_IDX - pass_q));

    f_less_or_equal u_fle (
        .a   (cmp_a),
        .b   (cmp_b),
        .res (cmp_res),
        .err (cmp_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_valid) begin
                    accept  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                step = 1'b1;
                if (cmp_err || (row_end && pass_q == LAST_PASS))
                    state_d = DONE;
            end
            DONE: begin
                if (down_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q <= '0;
            idx_q  <= '0;
            pass_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            elem_q <= up_data;
            idx_q  <= '0;
            pass_q <= '0;
            err_q  <= 1'b0;
        end else if (step) begin
            if (cmp_err) begin
                err_q <= 1'b1;
            end else begin
                // swap only on strict greater-than so equal keys keep input order
                if (!cmp_res) begin
                    elem_q[idx_q]   <= cmp_b;
                    elem_q[idx_nxt] <= cmp_a;
                end
                if (row_end) begin
                    idx_q  <= '0;
                    pass_q <= pass_q + IW'(1);
                end else begin
                    idx_q <= idx_nxt;
                end
            end
        end
    end

    assign up_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign down_valid = (state_q == DONE);
    assign down_data  = elem_q;
    assign down_err   = err_q;

endmodule

// File: tb/tb_sort_floats_seq.sv
// Bench for sort_floats_seq: directed jobs, a reference sorter, and a per-cycle output checker.
module tb_sort_floats_seq;
    import sort_floats_seq_pkg::*;

    localparam int N = 4;
    typedef logic [0:N-1][FLEN-1:0] data_t;

    localparam logic [63:0] P3  = 64'h4008000000000000;
    localparam logic [63:0] P1  = 64'h3FF0000000000000;
    localparam logic [63:0] P2  = 64'h4000000000000000;
    localparam logic [63:0] M1  = 64'hBFF0000000000000;
    localparam logic [63:0] QN  = 64'h7FF8000000000000;
    localparam logic [63:0] P55 = 64'h4016000000000000;
    localparam logic [63:0] M2  = 64'hC000000000000000;
    localparam logic [63:0] PZ  = 64'h0000000000000000;
    localparam logic [63:0] MZ  = 64'h8000000000000000;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  up_valid, up_ready, down_valid, down_ready, down_err, busy;
    data_t up_data, down_data;

    int    tests = 0;
    int    fails = 0;
    data_t exp_data;
    logic  exp_err;

    sort_floats_seq #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_err   (down_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*FLEN-1:0] got, input logic [N*FLEN-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bit is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    // Reference: a stable ascending sort when no NaN is present; with a NaN,
    // follow the fixed compare order until the first compare touching it.
    function automatic void model(input data_t d, output data_t o, output logic e, output int c);
        bit any_nan = 1'b0;
        o = d;
        e = 1'b0;
        c = 0;
        for (int i = 0; i < N; i++) any_nan |= is_nan(d[i]);
        if (!any_nan) begin
            for (int i = 1; i < N; i++) begin
                logic [63:0] key = o[i];
                int j = i - 1;
                while (j >= 0 && $bitstoreal(o[j]) > $bitstoreal(key)) begin
                    o[j+1] = o[j];
                    j--;
                end
                o[j+1] = key;
            end
            c = n_cmp(N);
        end else begin
            for (int p = 0; p < N - 1; p++) begin
                for (int i = 0; i < N - 1 - p; i++) begin
                    logic [63:0] t;
                    c++;
                    if (is_nan(o[i]) || is_nan(o[i+1])) begin
                        e = 1'b1;
                        return;
                    end
                    if ($bitstoreal(o[i]) > $bitstoreal(o[i+1])) begin
                        t      = o[i];
                        o[i]   = o[i+1];
                        o[i+1] = t;
                    end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && down_valid) begin
            check("cmp_data", down_data, exp_data);
            check("cmp_err", down_err, exp_err);
        end
    end

    task automatic set_expect(input data_t d, output int mc);
        data_t mo;
        logic  me;
        model(d, mo, me, mc);
        exp_data = mo;
        exp_err  = me;
    endtask

    task automatic job(input data_t d, input data_t lit, input logic lit_err, input int lit_cyc, input int hold);
        data_t mo;
        logic  me;
        int    mc;
        int    cnt;
        model(d, mo, me, mc);
        check("model_data", mo, lit);
        check("model_err", me, lit_err);
        check("model_cyc", mc, lit_cyc);
        exp_data = mo;
        exp_err  = me;
        up_data  = d;
        up_valid = 1'b1;
        cnt = 0;
        while (!up_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("up_ready_idle", up_ready, 1);
        @(posedge clk); #1;
        up_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        cnt = 0;
        while (!down_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", cnt, mc);
        check("dut_data_lit", down_data, lit);
        check("dut_err_lit", down_err, lit_err);
        for (int h = 0; h < hold; h++) begin
            up_valid = 1'b1;
            up_data  = ~d;
            check("up_ready_in_done", up_ready, 0);
            @(posedge clk); #1;
            check("valid_held", down_valid, 1);
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        @(posedge clk); #1;
        down_ready = 1'b0;
        check("valid_drop", down_valid, 0);
        check("up_ready_after", up_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        down_ready = 1'b0;
        up_data    = '0;
        exp_data   = '0;
        exp_err    = 1'b0;
        #3;
        check("rst_down_valid", down_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_down_err", down_err, 0);
        check("rst_down_data", down_data, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_up_ready", up_ready, 1);
        check("post_rst_busy", busy, 0);

        job({P3, P1, P2, M1}, {M1, P1, P2, P3}, 1'b0, 6, 0);
        job({P2, P2, P2, P2}, {P2, P2, P2, P2}, 1'b0, 6, 0);
        job({M1, P1, P2, P3}, {M1, P1, P2, P3}, 1'b0, 6, 0);
        job({P1, P2, QN, P3}, {P1, P2, QN, P3}, 1'b1, 2, 5);
        job({P55, M2, PZ, MZ}, {M2, PZ, MZ, P55}, 1'b0, 6, 2);

        // abort a job during its third compare cycle
        set_expect({P3, P1, P2, M1}, cnt);
        up_data  = {P3, P1, P2, M1};
        up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_down_valid", down_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_down_err", down_err, 0);
        check("abort_down_data", down_data, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("abort_up_ready", up_ready, 1);
        @(posedge clk); #1;
        job({P3, P1, P2, M1}, {M1, P1, P2, P3}, 1'b0, 6, 0);

        // back-to-back with both handshakes held high
        set_expect({P3, P1, P2, M1}, cnt);
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_data    = {P3, P1, P2, M1};
        @(posedge clk); #1;
        check("b2b_busy_a", busy, 1);
        cnt = 0;
        while (!down_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b_latency_a", cnt, n_cmp(N));
        check("b2b_data_a", down_data, {M1, P1, P2, P3});
        up_data = {P55, M2, PZ, MZ};
        @(posedge clk); #1;
        check("b2b_idle_valid", down_valid, 0);
        check("b2b_idle_ready", up_ready, 1);
        set_expect({P55, M2, PZ, MZ}, cnt);
        @(posedge clk); #1;
        check("b2b_busy_b", busy, 1);
        up_valid = 1'b0;
        cnt = 0;
        while (!down_valid && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b_latency_b", cnt, n_cmp(N));
        check("b2b_data_b", down_data, {M2, PZ, MZ, P55});
        @(posedge clk); #1;
        down_ready = 1'b0;
        check("b2b_final_valid", down_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
